// File: rtl/data_cache_if.sv
// Core/memory bus bundle for data_cache.
// slave  : cache view (core request in, load data/stall out; memory req out, rdata/ack in)
// master : environment view (core pipeline + backing memory)
interface data_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  rd_en_i;
  logic                  wr_en_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  stall_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport slave (
    input  rd_en_i, wr_en_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
    output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output rd_en_i, wr_en_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
    input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, one-word-per-line data cache.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : data_cache_if.slave -- core load/store request, load data,
//                  combinational stall, and req/ack backing-memory transaction
// Load hits return data combinationally with no stall; load misses and all
// stores stall while a memory transaction runs, then spend one RESP cycle
// unstalled so the pipeline advances exactly once.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  data_cache_if.slave bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  resp_rd_q;  // RESP follows a load (else a store)

  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic             hit, fill_en, upd_en;
  logic             unused_lsb;

  assign idx        = bus.addr_i[IDX+1:2];
  assign tag        = bus.addr_i[ADDR_WIDTH-1:IDX+2];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_lsb = ^bus.addr_i[1:0];
  // state_q is forced to IDLE while reset is high, so these never fire then
  assign fill_en    = (state_q == RD_WAIT) && bus.mem_ack_i;
  assign upd_en     = (state_q == WR_WAIT) && bus.mem_ack_i && hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      fill_q    <= '0;
      resp_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        fill_q       <= bus.mem_rdata_i;
        resp_rd_q    <= 1'b1;
      end
      if ((state_q == WR_WAIT) && bus.mem_ack_i) resp_rd_q <= 1'b0;
    end
  end

  // Tag/data storage needs no reset: valid_q gates every use
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rdata_i;
    end else if (upd_en) begin
      data_q[idx] <= bus.data_i;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.data_o      = '0;
    bus.stall_o     = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    // Outputs go quiet the instant reset rises, before any edge
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.wr_en_i) begin          // store wins over simultaneous load
            bus.stall_o = 1'b1;
            state_d     = WR_WAIT;
          end else if (bus.rd_en_i) begin
            if (hit) begin
              bus.data_o = data_q[idx];
            end else begin
              bus.stall_o = 1'b1;
              state_d     = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          bus.stall_o    = 1'b1;
          bus.mem_req_o  = 1'b1;
          bus.mem_addr_o = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
          if (bus.mem_ack_i) state_d = RESP;
        end
        WR_WAIT: begin
          bus.stall_o     = 1'b1;
          bus.mem_req_o   = 1'b1;
          bus.mem_we_o    = 1'b1;
          bus.mem_addr_o  = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
          bus.mem_wdata_o = bus.data_i;
          if (bus.mem_ack_i) state_d = RESP;
        end
        RESP: begin
          bus.data_o = resp_rd_q ? fill_q : '0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
